// File: rtl/pcie_sw_pkg.sv
// Shared definitions for the PCIe switch completion paths:
// descriptor offsets, error codes, FSM states and header conversion.
package pcie_sw_pkg;

  typedef enum logic [1:0] {
    SOP,
    PASS,
    DROP
  } sw_state_e;

  localparam int HDR_W         = 96;
  localparam int ERR_CODE_LSB  = 12;
  localparam int ERR_CODE_W    = 4;
  localparam int ERR_FATAL_BIT = 15;
  localparam int POISON_BIT    = 46;
  localparam int RC_SOP0_BIT   = 64;
  localparam int RC_DISC_BIT   = 96;
  localparam int CC_SOP_BIT    = 0;
  localparam int CC_DISC_BIT   = 80;

  localparam logic [3:0] ERR_NONE      = 4'h0;
  localparam logic [3:0] ERR_DROP_MASK = 4'h8;

  // Reserved/attribute fields cleared, completer-ID-enable forced.
  function automatic logic [HDR_W-1:0] rc_to_cc_hdr(
    input logic [HDR_W-1:0] rc
  );
    logic [HDR_W-1:0] cc;
    cc         = rc;
    cc[15:7]   = '0;
    cc[31:30]  = '0;
    cc[47]     = 1'b0;
    cc[88]     = 1'b1;
    cc[95]     = 1'b0;
    return cc;
  endfunction

endpackage

// File: rtl/axis_skid_buffer.sv
// Two-entry AXI-stream skid buffer with a registered in_ready,
// so out_ready never reaches in_ready combinationally.
module axis_skid_buffer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  input  logic [W-1:0] in_data,
  output logic         in_ready,
  output logic         out_valid,
  output logic [W-1:0] out_data,
  input  logic         out_ready
);

  logic [W-1:0] mem_q [2];
  logic [W-1:0] mem_d [2];
  logic [1:0]   cnt_q, cnt_d;
  logic         wr_q, wr_d;
  logic         rd_q, rd_d;
  logic         rdy_q, rdy_d;
  logic         push, pop;

  assign in_ready  = rdy_q;
  assign out_valid = (cnt_q != 2'd0);
  assign out_data  = mem_q[rd_q];

  always_comb begin
    push  = in_valid && rdy_q;
    pop   = out_valid && out_ready;
    mem_d = mem_q;
    cnt_d = cnt_q;
    wr_d  = wr_q;
    rd_d  = rd_q;
    if (push) begin
      mem_d[wr_q] = in_data;
      wr_d        = ~wr_q;
    end
    if (pop) begin
      rd_d = ~rd_q;
    end
    if (push && !pop) begin
      cnt_d = cnt_q + 2'd1;
    end else if (!push && pop) begin
      cnt_d = cnt_q - 2'd1;
    end
    rdy_d = (cnt_d != 2'd2);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= 2'd0;
      wr_q  <= 1'b0;
      rd_q  <= 1'b0;
      rdy_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      rdy_q <= rdy_d;
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/rc_to_cc_converter.sv
// Converts requester completions (RC) into completer completions (CC),
// dropping packets whose SOP carries a fatal error code.
module rc_to_cc_converter
  import pcie_sw_pkg::*;
#(
  parameter int IF_WIDTH       = 512,
  parameter int TKEEP_WIDTH    = 16,
  parameter int RC_TUSER_WIDTH = 161,
  parameter int CC_TUSER_WIDTH = 81
) (
  input  logic                      user_clk,
  input  logic                      sys_reset_n,
  input  logic [IF_WIDTH-1:0]       m_axis_rc_tdata,
  input  logic [TKEEP_WIDTH-1:0]    m_axis_rc_tkeep,
  input  logic                      m_axis_rc_tlast,
  input  logic [RC_TUSER_WIDTH-1:0] m_axis_rc_tuser,
  input  logic                      m_axis_rc_tvalid,
  output logic                      m_axis_rc_tready,
  output logic [IF_WIDTH-1:0]       s_axis_cc_tdata,
  output logic [TKEEP_WIDTH-1:0]    s_axis_cc_tkeep,
  output logic                      s_axis_cc_tlast,
  output logic [CC_TUSER_WIDTH-1:0] s_axis_cc_tuser,
  output logic                      s_axis_cc_tvalid,
  input  logic                      s_axis_cc_tready,
  output logic [15:0]               drop_count
);

  localparam int PW = IF_WIDTH + TKEEP_WIDTH + 2;

  logic [PW-1:0]          in_pl, h_pl;
  logic                   h_valid, pop;
  logic [IF_WIDTH-1:0]    h_data;
  logic [TKEEP_WIDTH-1:0] h_keep;
  logic                   h_last, h_disc, h_err;
  sw_state_e              state_q, state_d;
  logic [15:0]            drop_q, drop_d;
  logic                   unused_tuser;

  // Packet boundaries come from tlast; only discontinue rides along.
  assign unused_tuser = ^{m_axis_rc_tuser[RC_TUSER_WIDTH-1:RC_DISC_BIT+1],
                          m_axis_rc_tuser[RC_DISC_BIT-1:0]};

  assign in_pl = {m_axis_rc_tlast, m_axis_rc_tuser[RC_DISC_BIT],
                  m_axis_rc_tkeep, m_axis_rc_tdata};

  axis_skid_buffer #(
    .W (PW)
  ) u_skid (
    .clk       (user_clk),
    .rst_n     (sys_reset_n),
    .in_valid  (m_axis_rc_tvalid),
    .in_data   (in_pl),
    .in_ready  (m_axis_rc_tready),
    .out_valid (h_valid),
    .out_data  (h_pl),
    .out_ready (pop)
  );

  assign {h_last, h_disc, h_keep, h_data} = h_pl;
  assign h_err      = h_data[ERR_FATAL_BIT];
  assign drop_count = drop_q;

  always_comb begin
    state_d          = state_q;
    drop_d           = drop_q;
    pop              = 1'b0;
    s_axis_cc_tvalid = 1'b0;
    s_axis_cc_tdata  = h_data;
    s_axis_cc_tkeep  = h_keep;
    s_axis_cc_tlast  = h_last;
    s_axis_cc_tuser  = '0;
    s_axis_cc_tuser[CC_DISC_BIT] = h_disc;
    unique case (state_q)
      SOP: begin
        s_axis_cc_tdata = {h_data[IF_WIDTH-1:HDR_W],
                           rc_to_cc_hdr(h_data[HDR_W-1:0])};
        s_axis_cc_tuser[CC_SOP_BIT] = 1'b1;
        if (h_err) begin
          pop = h_valid;
          if (h_valid) begin
            if (drop_q != 16'hFFFF) drop_d = drop_q + 16'd1;
            if (!h_last) state_d = DROP;
          end
        end else begin
          s_axis_cc_tvalid = h_valid;
          pop = h_valid && s_axis_cc_tready;
          if (pop && !h_last) state_d = PASS;
        end
      end
      PASS: begin
        s_axis_cc_tvalid = h_valid;
        pop = h_valid && s_axis_cc_tready;
        if (pop && h_last) state_d = SOP;
      end
      DROP: begin
        pop = h_valid;
        if (pop && h_last) state_d = SOP;
      end
      default: state_d = SOP;
    endcase
  end

  always_ff @(posedge user_clk) begin
    if (!sys_reset_n) begin
      state_q <= SOP;
      drop_q  <= 16'd0;
    end else begin
      state_q <= state_d;
      drop_q  <= drop_d;
    end
  end

endmodule

// File: tb/tb_rc_to_cc_converter.sv
// Scoreboard bench for rc_to_cc_converter: expected CC beats are
// queued as RC beats are driven and popped on each CC handshake.
module tb_rc_to_cc_converter;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [511:0] rc_tdata;
  logic [15:0]  rc_tkeep;
  logic         rc_tlast;
  logic [160:0] rc_tuser;
  logic         rc_tvalid;
  logic         rc_tready;
  logic [511:0] cc_tdata;
  logic [15:0]  cc_tkeep;
  logic         cc_tlast;
  logic [80:0]  cc_tuser;
  logic         cc_tvalid;
  logic         cc_tready;
  logic [15:0]  drop_count;

  typedef struct {
    logic [511:0] d;
    logic [15:0]  k;
    logic         l;
    logic [80:0]  u;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  bit   bp_chk = 0;
  int   occ = 0;
  bit   hold_v = 0;
  exp_t hold;

  always #5 clk = ~clk;

  rc_to_cc_converter dut (
    .user_clk         (clk),
    .sys_reset_n      (rst_n),
    .m_axis_rc_tdata  (rc_tdata),
    .m_axis_rc_tkeep  (rc_tkeep),
    .m_axis_rc_tlast  (rc_tlast),
    .m_axis_rc_tuser  (rc_tuser),
    .m_axis_rc_tvalid (rc_tvalid),
    .m_axis_rc_tready (rc_tready),
    .s_axis_cc_tdata  (cc_tdata),
    .s_axis_cc_tkeep  (cc_tkeep),
    .s_axis_cc_tlast  (cc_tlast),
    .s_axis_cc_tuser  (cc_tuser),
    .s_axis_cc_tvalid (cc_tvalid),
    .s_axis_cc_tready (cc_tready),
    .drop_count       (drop_count)
  );

  function automatic logic [511:0] exp_hdr(input logic [511:0] rc);
    return {rc[511:96], 1'b0, rc[94:89], 1'b1, rc[87:48], 1'b0,
            rc[46:32], 2'b00, rc[29], rc[28:16], 9'd0, rc[6:0]};
  endfunction

  function automatic logic [511:0] rand512();
    logic [511:0] d;
    for (int i = 0; i < 16; i++) d[i*32 +: 32] = $urandom;
    return d;
  endfunction

  always @(negedge clk) begin
    if (!rst_n) begin
      hold_v = 0;
      occ = 0;
    end else begin
      if (bp_chk) begin
        checks++;
        if (rc_tready !== (occ != 2)) begin
          errors++;
          $display("FAIL rc_tready_vs_full got %b occ %0d", rc_tready, occ);
        end
      end
      if (hold_v) begin
        checks++;
        if (cc_tvalid !== 1'b1 || cc_tdata !== hold.d ||
            cc_tkeep !== hold.k || cc_tlast !== hold.l ||
            cc_tuser !== hold.u) begin
          errors++;
          $display("FAIL cc_hold_stable got valid %b user %h exp user %h",
                   cc_tvalid, cc_tuser, hold.u);
        end
      end
      if (cc_tvalid === 1'b1 && cc_tready === 1'b1) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL cc_unexpected_beat got %h exp none", cc_tdata[95:0]);
        end else begin
          exp_t e;
          e = sb.pop_front();
          if (cc_tdata !== e.d || cc_tkeep !== e.k ||
              cc_tlast !== e.l || cc_tuser !== e.u) begin
            errors++;
            $display("FAIL cc_beat got d %h k %h l %b u %h exp d %h k %h l %b u %h",
                     cc_tdata[127:0], cc_tkeep, cc_tlast, cc_tuser,
                     e.d[127:0], e.k, e.l, e.u);
          end
        end
      end
      hold_v = (cc_tvalid === 1'b1) && (cc_tready !== 1'b1);
      hold.d = cc_tdata;
      hold.k = cc_tkeep;
      hold.l = cc_tlast;
      hold.u = cc_tuser;
      if (!bp_chk) occ = 0;
      else occ = occ + int'(rc_tvalid && rc_tready) - int'(cc_tvalid && cc_tready);
    end
  end

  task automatic send_beat(input logic [511:0] d, input logic [15:0] k,
                           input logic l, input logic disc, input logic sop);
    int n;
    rc_tdata = d;
    rc_tkeep = k;
    rc_tlast = l;
    for (int i = 0; i < 161; i++) rc_tuser[i] = 1'($urandom_range(0, 1));
    rc_tuser[64] = sop;
    rc_tuser[96] = disc;
    rc_tvalid = 1'b1;
    n = 0;
    @(negedge clk);
    while (rc_tready !== 1'b1 && n < 1000) begin
      n++;
      @(negedge clk);
    end
    if (n >= 1000) begin
      checks++;
      errors++;
      $display("FAIL rc_accept_timeout got ready %b exp 1", rc_tready);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input logic [511:0] d, input logic [15:0] k,
                          input logic l, input logic disc, input logic sop);
    exp_t e;
    e.d = sop ? exp_hdr(d) : d;
    e.k = k;
    e.l = l;
    e.u = {disc, 79'd0, sop};
    sb.push_back(e);
  endtask

  task automatic send_pkt(input int nb, input logic [3:0] err,
                          input logic poison, input logic disc_last);
    logic [511:0] d;
    logic [15:0]  k;
    logic         l, disc;
    for (int b = 0; b < nb; b++) begin
      d = rand512();
      k = 16'($urandom);
      l = (b == nb - 1);
      disc = l && disc_last;
      if (b == 0) begin
        d[15:12] = err;
        d[46] = poison;
        d[47] = 1'b0;
      end
      if (!err[3]) push_exp(d, k, l, disc, b == 0);
      send_beat(d, k, l, disc, b == 0);
    end
    rc_tvalid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 2000) begin
      @(posedge clk);
      n++;
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout got %0d pending exp 0", sb.size());
    end
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    rc_tvalid = 1'b0;
    rc_tdata = '0;
    rc_tkeep = '0;
    rc_tlast = 1'b0;
    rc_tuser = '0;
    cc_tready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (rc_tready !== 1'b0 || cc_tvalid !== 1'b0 || drop_count !== 16'd0) begin
      errors++;
      $display("FAIL reset_state got rdy %b vld %b drop %h exp 0 0 0000",
               rc_tready, cc_tvalid, drop_count);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (rc_tready !== 1'b0) begin
      errors++;
      $display("FAIL ready_before_edge got %b exp 0", rc_tready);
    end
    @(posedge clk);
    #1;
    checks++;
    if (rc_tready !== 1'b1) begin
      errors++;
      $display("FAIL ready_after_release got %b exp 1", rc_tready);
    end
  endtask

  task automatic test_reset_midstream();
    logic [511:0] d;
    logic [15:0]  k;
    cc_tready = 1'b1;
    d = rand512();
    d[15:12] = 4'h0;
    d[47] = 1'b0;
    k = 16'($urandom);
    push_exp(d, k, 1'b0, 1'b0, 1'b1);
    send_beat(d, k, 1'b0, 1'b0, 1'b1);
    send_beat(rand512(), 16'($urandom), 1'b0, 1'b0, 1'b0);
    rst_n = 1'b0;
    rc_tvalid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL midstream_first_beat got %0d pending exp 0", sb.size());
    end
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    d = rand512();
    d[15:12] = 4'h2;
    d[47] = 1'b0;
    k = 16'($urandom);
    push_exp(d, k, 1'b1, 1'b0, 1'b1);
    send_beat(d, k, 1'b1, 1'b0, 1'b1);
    rc_tvalid = 1'b0;
    checks++;
    if (cc_tvalid !== 1'b1 || cc_tuser[0] !== 1'b1 || cc_tdata[88] !== 1'b1) begin
      errors++;
      $display("FAIL midstream_sop got vld %b sop %b b88 %b exp 1 1 1",
               cc_tvalid, cc_tuser[0], cc_tdata[88]);
    end
    drain();
    checks++;
    if (drop_count !== 16'd0) begin
      errors++;
      $display("FAIL midstream_drop got %h exp 0000", drop_count);
    end
  endtask

  task automatic test_normal();
    logic [511:0] d;
    logic [15:0]  k;
    cc_tready = 1'b1;
    for (int b = 0; b < 3; b++) begin
      d = rand512();
      k = 16'($urandom);
      if (b == 0) begin
        d[11:0] = 12'h7C4;
        d[15:12] = 4'h0;
        d[47] = 1'b0;
      end
      push_exp(d, k, b == 2, 1'b0, b == 0);
      send_beat(d, k, b == 2, 1'b0, b == 0);
      if (b == 0) begin
        checks++;
        if (cc_tvalid !== 1'b1 || cc_tuser[0] !== 1'b1 ||
            cc_tdata[6:0] !== 7'h44 || cc_tdata[15:7] !== 9'd0 ||
            cc_tdata[88] !== 1'b1) begin
          errors++;
          $display("FAIL normal_latency_hdr got vld %b sop %b la %h b88 %b exp 1 1 44 1",
                   cc_tvalid, cc_tuser[0], cc_tdata[6:0], cc_tdata[88]);
        end
      end
    end
    rc_tvalid = 1'b0;
    drain();
  endtask

  task automatic test_error_drop();
    cc_tready = 1'b1;
    send_pkt(1, 4'b1001, 1'b0, 1'b0);
    rc_tvalid = 1'b1;
    checks++;
    if (cc_tvalid !== 1'b0) begin
      errors++;
      $display("FAIL drop_no_valid got %b exp 0", cc_tvalid);
    end
    send_pkt(1, 4'b0000, 1'b0, 1'b0);
    drain();
    sb.delete();
    send_pkt(2, 4'b1001, 1'b0, 1'b0);
    send_pkt(3, 4'b0000, 1'b0, 1'b0);
    drain();
    checks++;
    if (drop_count !== 16'd2) begin
      errors++;
      $display("FAIL error_drop_count got %h exp 0002", drop_count);
    end
  endtask

  task automatic test_poison_disc();
    logic [511:0] d;
    logic [15:0]  k;
    cc_tready = 1'b1;
    d = rand512();
    d[15:12] = 4'b0001;
    d[46] = 1'b1;
    d[47] = 1'b0;
    k = 16'($urandom);
    push_exp(d, k, 1'b0, 1'b0, 1'b1);
    send_beat(d, k, 1'b0, 1'b0, 1'b1);
    checks++;
    if (cc_tdata[46] !== 1'b1) begin
      errors++;
      $display("FAIL poison_fwd got %b exp 1", cc_tdata[46]);
    end
    d = rand512();
    k = 16'($urandom);
    push_exp(d, k, 1'b1, 1'b1, 1'b0);
    send_beat(d, k, 1'b1, 1'b1, 1'b0);
    rc_tvalid = 1'b0;
    checks++;
    if (cc_tuser[80] !== 1'b1 || cc_tuser[0] !== 1'b0) begin
      errors++;
      $display("FAIL disc_fwd got disc %b sop %b exp 1 0", cc_tuser[80], cc_tuser[0]);
    end
    drain();
  endtask

  task automatic test_backpressure();
    bit done;
    done = 0;
    bp_chk = 1;
    fork
      begin
        for (int p = 0; p < 100; p++) begin
          send_pkt($urandom_range(1, 4), 4'($urandom_range(0, 7)), 1'b0,
                   1'($urandom_range(0, 1)));
        end
        done = 1;
      end
      begin
        while (!done) begin
          @(posedge clk);
          #1;
          cc_tready = 1'($urandom_range(0, 1));
        end
      end
    join
    cc_tready = 1'b1;
    drain();
    bp_chk = 0;
  endtask

  task automatic test_saturation();
    cc_tready = 1'b1;
    for (int p = 0; p < 65540; p++) begin
      send_pkt(1, {1'b1, 3'($urandom_range(0, 7))}, 1'b0, 1'b0);
    end
    drain();
    checks++;
    if (drop_count !== 16'hFFFF) begin
      errors++;
      $display("FAIL drop_saturate got %h exp ffff", drop_count);
    end
    send_pkt(2, 4'h0, 1'b0, 1'b0);
    drain();
    checks++;
    if (drop_count !== 16'hFFFF) begin
      errors++;
      $display("FAIL drop_hold got %h exp ffff", drop_count);
    end
  endtask

  initial begin
    test_reset();
    test_reset_midstream();
    test_normal();
    test_error_drop();
    test_poison_disc();
    test_backpressure();
    test_saturation();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
